lcd_line_writer: RTL

Serial frame engine for the LS013B7DH01 memory LCD. It sits directly downstream of `clk_divider`: it consumes the divided clock as a bit-rate reference and drives the panel's SCS, SCLK and SI pins. It sends either a single-line write or an all-clear command, and carries the host-supplied VCOM bit. All logic runs in the `clk_12mhz` domain; the divided clock is only sampled, never used as a clock.

---
 rtl/lcd_line_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lcd_line_writer.sv
// Serial frame engine for the LS013B7DH01 memory LCD: emits one line-write or
// all-clear frame on SCS/SCLK/SI, paced by ticks from rising edges of clk_div_in.
module lcd_line_writer #(
  parameter int LINE_BITS       = 144,
  parameter int SCS_SETUP_TICKS = 4,
  parameter int SCS_HOLD_TICKS  = 2
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  input  logic                 clk_div_in,
  input  logic                 start,
  input  logic                 clear_cmd,
  input  logic [7:0]           line_addr,
  input  logic [LINE_BITS-1:0] line_data,
  input  logic                 vcom,
  output logic                 busy,
  output logic                 done,
  output logic                 lcd_scs,
  output logic                 lcd_sclk,
  output logic                 lcd_si
);

  localparam int N_WRITE = LINE_BITS + 32;
  localparam int N_CLEAR = 16;
  localparam int BW      = $clog2(N_WRITE + 1);
  localparam int TMAX    = ((SCS_SETUP_TICKS > SCS_HOLD_TICKS) ? SCS_SETUP_TICKS : SCS_HOLD_TICKS) + 1;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic               sync1_reg, sync2_reg, sync3_reg;
  logic               tick;
  logic [1:0]         state_reg;
  logic [N_WRITE-1:0] frame_reg;
  logic [N_WRITE-1:0] write_frame;
  logic [N_WRITE-1:0] clear_frame;
  logic [BW-1:0]      bit_cnt_reg;
  logic [BW-1:0]      last_bit_reg;
  logic [TW-1:0]      tick_cnt_reg;
  logic               phase_reg;
  logic               busy_reg, done_reg, scs_reg, sclk_reg, si_reg;

  assign tick = sync2_reg & ~sync3_reg;

  // Frames are stored bit-0-first so shifting right presents the next bit at [0].
  always_comb begin
    write_frame                  = '0;
    write_frame[0]               = 1'b1;
    write_frame[1]               = vcom;
    write_frame[15:8]            = line_addr;
    write_frame[16 +: LINE_BITS] = line_data;
    clear_frame                  = '0;
    clear_frame[1]               = vcom;
    clear_frame[2]               = 1'b1;
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= clk_div_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      frame_reg    <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= '0;
      tick_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      scs_reg      <= 1'b0;
      sclk_reg     <= 1'b0;
      si_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start || clear_cmd) begin
            frame_reg    <= clear_cmd ? clear_frame : write_frame;
            last_bit_reg <= clear_cmd ? BW'(N_CLEAR - 1) : BW'(N_WRITE - 1);
            bit_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            scs_reg      <= 1'b1;
            state_reg    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            if (tick_cnt_reg == TW'(SCS_SETUP_TICKS - 1)) begin
              tick_cnt_reg <= '0;
              state_reg    <= ST_SHIFT;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // Phase 0 drops SCLK and presents data; phase 1 raises SCLK on stable data.
          if (tick) begin
            if (!phase_reg) begin
              sclk_reg  <= 1'b0;
              si_reg    <= frame_reg[0];
              phase_reg <= 1'b1;
            end else begin
              sclk_reg  <= 1'b1;
              phase_reg <= 1'b0;
              frame_reg <= frame_reg >> 1;
              if (bit_cnt_reg == last_bit_reg) begin
                tick_cnt_reg <= '0;
                state_reg    <= ST_HOLD;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
        end
        default: begin
          // First HOLD tick is the final SCLK fall; SCS drops HOLD_TICKS later.
          if (tick) begin
            if (tick_cnt_reg == '0) begin
              sclk_reg <= 1'b0;
              si_reg   <= 1'b0;
            end
            if (tick_cnt_reg == TW'(SCS_HOLD_TICKS)) begin
              scs_reg   <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign lcd_scs  = scs_reg;
  assign lcd_sclk = sclk_reg;
  assign lcd_si   = si_reg;

endmodule
